rotary_param_bank: RTL and testbench



---
 rtl/rotary_param_bank_pkg.sv | 9 +
 rtl/rotary_param_defs.vh | 14 +
 rtl/rotary_step_accel.sv | 38 +++
 rtl/rotary_param_bank.sv | 83 ++++++++
 tb/tb_rotary_param_bank.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rotary_param_bank_pkg.sv
// rotary_param_bank_pkg: types and helpers shared by rotary_param_bank and its accelerator.
package rotary_param_bank_pkg;
`include "rotary_param_defs.vh"

    // Both pulses at once cancel out to no step.
    function automatic dir_e step_dir(input logic cw, input logic ccw);
        return (cw ^ ccw) ? (cw ? DIR_CW : DIR_CCW) : DIR_NONE;
    endfunction
endpackage

// File: rtl/rotary_param_defs.vh
// rotary_param_defs.vh: step direction encodings and the index-width helper
// shared by the rotary_param_bank slice.
`ifndef ROTARY_PARAM_DEFS_VH
`define ROTARY_PARAM_DEFS_VH
typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
} dir_e;

function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
endfunction
`endif

// File: rtl/rotary_step_accel.sv
// rotary_step_accel: gap counter and last-direction tracking that choose the step size;
// compiled only when ROTARY_PARAM_BANK_ACCEL_EN is defined.
`ifdef ROTARY_PARAM_BANK_ACCEL_EN
module rotary_step_accel import rotary_param_bank_pkg::*; #(
    parameter int WIDTH        = 8,
    parameter int ACCEL_WINDOW = 50000,
    parameter int ACCEL_STEP   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  dir_e             dir_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] delta_o
);
    localparam int GW = idx_w(ACCEL_WINDOW + 1);

    dir_e          last_q, last_d;
    logic [GW-1:0] gap_q, gap_d;

    always_comb begin
        delta_o = (dir_i != DIR_NONE && dir_i == last_q && gap_q < GW'(ACCEL_WINDOW))
                  ? WIDTH'(ACCEL_STEP) : WIDTH'(1);
        last_d  = clear_i ? DIR_NONE : ((dir_i != DIR_NONE) ? dir_i : last_q);
        gap_d   = (dir_i != DIR_NONE) ? '0
                  : ((gap_q == GW'(ACCEL_WINDOW)) ? gap_q : gap_q + 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= DIR_NONE;
            gap_q  <= '0;
        end else begin
            last_q <= last_d;
            gap_q  <= gap_d;
        end
    end
endmodule
`endif

// File: rtl/rotary_param_bank.sv
// rotary_param_bank: one rotary encoder shared across CHANNELS parameter registers.
// Define ROTARY_PARAM_BANK_ACCEL_EN to enable step acceleration (rotary_step_accel).
module rotary_param_bank import rotary_param_bank_pkg::*; #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 8,
    parameter int RESET_VALUE  = 0,
    parameter int WRAP         = 0,
    parameter int ACCEL_WINDOW = 50000,
    parameter int ACCEL_STEP   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_ccw,
    input  logic                          in_cw,
    input  logic                          in_next,
    output logic [CHANNELS*WIDTH-1:0]     values,
    output logic [idx_w(CHANNELS)-1:0]    sel,
    output logic                          changed,
    output logic [idx_w(CHANNELS)-1:0]    changed_ch
);
    localparam int SW = idx_w(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] vals_q, vals_d;
    logic [SW-1:0]                  sel_q, sel_d, ch_q, ch_d;
    logic                           chg_q, chg_d;
    logic [WIDTH-1:0]               delta, cur, nv;
    logic [WIDTH:0]                 up, dn;
    dir_e                           dir;

    assign dir = step_dir(in_cw, in_ccw);

`ifdef ROTARY_PARAM_BANK_ACCEL_EN
    rotary_step_accel #(
        .WIDTH(WIDTH),
        .ACCEL_WINDOW(ACCEL_WINDOW),
        .ACCEL_STEP(ACCEL_STEP)
    ) u_accel (
        .clk(clk),
        .rst_n(rst_n),
        .dir_i(dir),
        .clear_i(in_next | (in_cw & in_ccw)),
        .delta_o(delta)
    );
`else
    logic unused_accel;
    assign unused_accel = ^{ACCEL_WINDOW[0], ACCEL_STEP[0]};
    assign delta = WIDTH'(1);
`endif

    // The extra top bit of up/dn flags overflow/underflow for the clamp.
    always_comb begin
        cur    = vals_q[sel_q];
        up     = {1'b0, cur} + {1'b0, delta};
        dn     = {1'b0, cur} - {1'b0, delta};
        nv     = (dir == DIR_CW)
                 ? ((up[WIDTH] && WRAP == 0) ? '1 : up[WIDTH-1:0])
                 : ((dn[WIDTH] && WRAP == 0) ? '0 : dn[WIDTH-1:0]);
        chg_d  = (dir != DIR_NONE) && (nv != cur);
        ch_d   = chg_d ? sel_q : ch_q;
        sel_d  = in_next ? ((sel_q == SW'(CHANNELS - 1)) ? '0 : sel_q + 1'b1) : sel_q;
        vals_d = vals_q;
        if (chg_d) vals_d[sel_q] = nv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vals_q <= {CHANNELS{WIDTH'(RESET_VALUE)}};
            sel_q  <= '0;
            ch_q   <= '0;
            chg_q  <= 1'b0;
        end else begin
            vals_q <= vals_d;
            sel_q  <= sel_d;
            ch_q   <= ch_d;
            chg_q  <= chg_d;
        end
    end

    assign values     = vals_q;
    assign sel        = sel_q;
    assign changed    = chg_q;
    assign changed_ch = ch_q;
endmodule

// File: tb/tb_rotary_param_bank.sv
// tb_rotary_param_bank: directed stimulus with a changed-pulse scoreboard for a
// saturating (d0) and a wrapping (d1) instance.
module tb_rotary_param_bank;
`ifdef ROTARY_PARAM_BANK_ACCEL_EN
    localparam int ACC = 8;
`else
    localparam int ACC = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cw = 1'b0, ccw = 1'b0, nx = 1'b0;
    logic wcw = 1'b0, wccw = 1'b0, wnx = 1'b0;
    logic [31:0] v0, v1;
    logic [1:0]  s0, s1, c0ch, c1ch;
    logic        c0, c1;

    always #5 clk = ~clk;

    rotary_param_bank #(.CHANNELS(4), .WIDTH(8), .RESET_VALUE(0), .WRAP(0),
                        .ACCEL_WINDOW(10), .ACCEL_STEP(8)) d0 (
        .clk(clk), .rst_n(rst_n), .in_ccw(ccw), .in_cw(cw), .in_next(nx),
        .values(v0), .sel(s0), .changed(c0), .changed_ch(c0ch));

    rotary_param_bank #(.CHANNELS(4), .WIDTH(8), .RESET_VALUE(0), .WRAP(1),
                        .ACCEL_WINDOW(10), .ACCEL_STEP(8)) d1 (
        .clk(clk), .rst_n(rst_n), .in_ccw(wccw), .in_cw(wcw), .in_next(wnx),
        .values(v1), .sel(s1), .changed(c1), .changed_ch(c1ch));

    typedef struct {int ch; int val;} exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && c0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d0_unexpected_changed: got ch %0d expected no pulse", c0ch);
            end else begin
                e = q0.pop_front();
                chk("d0_changed_ch", c0ch, e.ch);
                chk("d0_value", v0[e.ch*8 +: 8], e.val);
            end
        end
        if (rst_n && c1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d1_unexpected_changed: got ch %0d expected no pulse", c1ch);
            end else begin
                e = q1.pop_front();
                chk("d1_changed_ch", c1ch, e.ch);
                chk("d1_value", v1[e.ch*8 +: 8], e.val);
            end
        end
    end

    task automatic drv(input logic a, input logic b, input logic n);
        cw = a; ccw = b; nx = n;
        @(posedge clk); #1;
        cw = 1'b0; ccw = 1'b0; nx = 1'b0;
    endtask

    task automatic drv1(input logic a, input logic b);
        wcw = a; wccw = b;
        @(posedge clk); #1;
        wcw = 1'b0; wccw = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        int ne;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_values", v0, 0);
        chk("reset_sel", s0, 0);
        chk("reset_changed", c0, 0);
        chk("reset_changed_ch", c0ch, 0);
        rst_n = 1'b1;
        idle(1);

        q0.push_back('{0, 1});
        q0.push_back('{0, 1 + ACC});
        q0.push_back('{0, 1 + 2*ACC});
        drv(1, 0, 0); drv(1, 0, 0); drv(1, 0, 0);
        idle(1);
        chk("ch0_after_3cw", v0[7:0], 1 + 2*ACC);
        chk("others_zero", v0[31:8], 0);

        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 1);
            chk("sel_seq", s0, (i + 1) % 4);
        end
        chk("values_hold_on_next", v0, 1 + 2*ACC);

        cw = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_values", v0, 0);
        chk("async_reset_sel", s0, 0);
        chk("async_reset_changed", c0, 0);
        cw = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        drv(0, 1, 0);
        idle(1);
        chk("sat_low", v0[7:0], 0);

        e = 0;
        for (int i = 0; e < 255; i++) begin
            ne = e + ((i == 0) ? 1 : ACC);
            if (ne > 255) ne = 255;
            q0.push_back('{0, ne});
            e = ne;
            drv(1, 0, 0);
        end
        drv(1, 0, 0);
        idle(1);
        chk("sat_high", v0[7:0], 255);

        q0.push_back('{0, 254});
        drv(0, 1, 0);
        drv(1, 1, 0);
        q0.push_back('{0, 253});
        drv(0, 1, 0);
        idle(1);
        chk("both_ignored", v0[7:0], 253);

        drv(0, 0, 1);
        drv(0, 0, 1);
        chk("sel_is_2", s0, 2);
        q0.push_back('{2, 1});
        drv(1, 0, 1);
        chk("sel_after_next_step", s0, 3);
        idle(1);
        chk("ch2_stepped", v0[23:16], 1);
        chk("ch0_held", v0[7:0], 253);

        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        q0.push_back('{0, 1});
        drv(1, 0, 0);
        idle(4);
        q0.push_back('{0, 1 + ACC});
        drv(1, 0, 0);
        idle(4);
        q0.push_back('{0, 1 + 2*ACC});
        drv(1, 0, 0);
        idle(19);
        q0.push_back('{0, 2 + 2*ACC});
        drv(1, 0, 0);
        idle(1);
        q0.push_back('{0, 1 + 2*ACC});
        drv(0, 1, 0);
        idle(2);
        chk("accel_seq_end", v0[7:0], 1 + 2*ACC);

        q1.push_back('{0, 255});
        drv1(0, 1);
        q1.push_back('{0, 0});
        drv1(1, 0);
        idle(2);
        chk("wrap_ch0", v1[7:0], 0);
        chk("wrap_sel", s1, 0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
